ram_range_reader: RTL and testbench

//  Sequencer for the shared storage RAM. On a start pulse it latches the range from the step

---
 rtl/ram_range_reader.sv | 120 ++++++++++++
 tb/tb_ram_range_reader.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_range_reader.sv
// Range sequencer for the shared storage RAM: on start it reads [firstaddr, lastaddr)
// one word per cycle and streams the returned words into a buffer re-based to index 0.
module ram_range_reader #(
    parameter int DATA_W  = 19,
    parameter int ADDR_W  = 15,
    parameter int RAM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              re_RAM,
    input  logic [ADDR_W-1:0] firstaddr,
    input  logic [ADDR_W-1:0] lastaddr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_re,
    input  logic [DATA_W-1:0] ram_q,
    output logic              buf_we,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [DATA_W-1:0] buf_data,
    output logic              busy,
    output logic              done,
    output logic [1:0]        dbg_state
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_last;
    logic [ADDR_W-1:0]   r_widx;
    logic [RAM_LAT-1:0]  r_vld;
    logic [RAM_LAT:0]    w_vld_ext;
    logic                w_issue;
    logic                w_last_issue;
    logic                w_ret;
    logic                w_range_ok;
    logic                w_accept;

    assign w_issue      = (r_state == S_ISSUE);
    assign w_last_issue = w_issue && (r_addr == (r_last - ADDR_ONE));
    // Bit 0 is the read being issued now; bit RAM_LAT-1 of r_vld marks the word on ram_q.
    assign w_vld_ext    = {r_vld, w_issue};
    assign w_ret        = r_vld[RAM_LAT-1];
    assign w_range_ok   = re_RAM && (lastaddr > firstaddr);

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = w_range_ok ? S_ISSUE : S_DONE;
                end
            end
            S_ISSUE: begin
                if (w_last_issue) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Leave once no read remains in flight after this cycle.
                if (w_vld_ext[RAM_LAT-1:0] == '0) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_last  <= '0;
            r_widx  <= '0;
            r_vld   <= '0;
        end else begin
            r_state <= w_state_next;
            r_vld   <= w_vld_ext[RAM_LAT-1:0];
            if (w_accept) begin
                r_last <= lastaddr;
                if (w_range_ok) begin
                    r_addr <= firstaddr;
                end
            end else if (w_issue && !w_last_issue) begin
                r_addr <= r_addr + ADDR_ONE;
            end
            if (w_accept) begin
                r_widx <= '0;
            end else if (w_ret) begin
                r_widx <= r_widx + ADDR_ONE;
            end
        end
    end

    // An empty range goes straight to DONE, so busy never rises for it.
    assign ram_addr  = r_addr;
    assign ram_re    = w_issue;
    assign buf_we    = w_ret;
    assign buf_addr  = r_widx;
    assign buf_data  = w_ret ? ram_q : '0;
    assign busy      = (r_state == S_ISSUE) || (r_state == S_DRAIN);
    assign done      = (r_state == S_DONE);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_ram_range_reader.sv
// Bench for ram_range_reader: one instance with RAM_LAT=1 and one with RAM_LAT=3 share the
// same inputs; each has its own RAM model and a timing model derived from the range rules.
module tb_ram_range_reader;

    localparam int DW    = 19;
    localparam int AW    = 15;
    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          start;
    logic          re_ram;
    logic [AW-1:0] firstaddr;
    logic [AW-1:0] lastaddr;

    logic [AW-1:0] ram_addr_a, ram_addr_b, buf_addr_a, buf_addr_b;
    logic          ram_re_a, ram_re_b, buf_we_a, buf_we_b;
    logic          busy_a, busy_b, done_a, done_b;
    logic [DW-1:0] ram_q_a, ram_q_b, buf_data_a, buf_data_b;
    logic [1:0]    dbg_a, dbg_b;

    ram_range_reader #(.DATA_W(DW), .ADDR_W(AW), .RAM_LAT(LAT_A)) u_dut_a (
        .clk(clk), .rst(rst), .start(start), .re_RAM(re_ram),
        .firstaddr(firstaddr), .lastaddr(lastaddr),
        .ram_addr(ram_addr_a), .ram_re(ram_re_a), .ram_q(ram_q_a),
        .buf_we(buf_we_a), .buf_addr(buf_addr_a), .buf_data(buf_data_a),
        .busy(busy_a), .done(done_a), .dbg_state(dbg_a)
    );

    ram_range_reader #(.DATA_W(DW), .ADDR_W(AW), .RAM_LAT(LAT_B)) u_dut_b (
        .clk(clk), .rst(rst), .start(start), .re_RAM(re_ram),
        .firstaddr(firstaddr), .lastaddr(lastaddr),
        .ram_addr(ram_addr_b), .ram_re(ram_re_b), .ram_q(ram_q_b),
        .buf_we(buf_we_b), .buf_addr(buf_addr_b), .buf_data(buf_data_b),
        .busy(busy_b), .done(done_b), .dbg_state(dbg_b)
    );

    // Storage RAM contents and per-instance read pipelines of the given latency.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] qb0, qb1;

    always @(posedge clk) ram_q_a <= mem[ram_addr_a];
    always @(posedge clk) begin
        qb0     <= mem[ram_addr_b];
        qb1     <= qb0;
        ram_q_b <= qb1;
    end

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: one transaction record per instance, timed in edges since the accept.
    int            e = 0;
    bit            m_active [2];
    int            m_acc    [2];
    int            m_n      [2];
    logic [AW-1:0] m_first  [2];
    logic [AW-1:0] m_hold   [2];
    bit            m_just_rst;
    int            m_wcount [2];
    int            m_first_we [2];
    int            m_last_we  [2];
    int            m_busy_cnt [2];
    int            m_done_off [2];
    int            m_we_idle  [2];
    int            m_accepts  [2];

    function automatic int lat_of(input int i);
        return (i == 0) ? LAT_A : LAT_B;
    endfunction

    function automatic int done_off(input int i);
        return (m_n[i] > 0) ? m_n[i] + lat_of(i) + 1 : 1;
    endfunction

    function automatic bit model_idle(input int i);
        return !m_active[i] || ((e - m_acc[i] + 1) > done_off(i));
    endfunction

    always @(posedge clk) begin
        bit idle_now [2];
        for (int i = 0; i < 2; i++) idle_now[i] = model_idle(i);
        e = e + 1;
        m_just_rst = rst;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_active[i]  = 1'b0;
                m_hold[i]    = '0;
                m_we_idle[i] = 0;
            end else if (start && idle_now[i]) begin
                m_active[i]   = 1'b1;
                m_acc[i]      = e;
                m_first[i]    = firstaddr;
                m_n[i]        = (re_ram && (lastaddr > firstaddr)) ? int'(lastaddr) - int'(firstaddr) : 0;
                if (m_n[i] > 0) m_hold[i] = AW'(int'(lastaddr) - 1);
                m_wcount[i]   = 0;
                m_first_we[i] = -1;
                m_last_we[i]  = -1;
                m_busy_cnt[i] = 0;
                m_done_off[i] = -1;
                m_accepts[i]  = m_accepts[i] + 1;
            end
        end
    end

    task automatic chk(input int i, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 30)
                $display("FAIL %s dut%0d (lat %0d) edge %0d: got %0h, expected %0h",
                         name, i, lat_of(i), e, act, exp);
        end
    endtask

    task automatic lit(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_dut(input int i, input logic re, input logic [AW-1:0] addr, input logic we,
                             input logic [AW-1:0] baddr, input logic [DW-1:0] bdata,
                             input logic bsy, input logic dn);
        int l, n, off;
        bit in_txn, e_re, e_we, e_busy, e_done;
        logic [AW-1:0] e_addr;
        l      = lat_of(i);
        n      = m_n[i];
        off    = e - m_acc[i] + 1;
        in_txn = m_active[i] && (off <= done_off(i));
        e_re   = in_txn && (n > 0) && (off <= n);
        e_we   = in_txn && (n > 0) && (off >= 1 + l) && (off <= n + l);
        e_busy = in_txn && (n > 0) && (off <= n + l);
        e_done = in_txn && (off == done_off(i));
        e_addr = e_re ? AW'(int'(m_first[i]) + off - 1) : m_hold[i];
        chk(i, "ram_re",   32'(re),   32'(e_re));
        chk(i, "ram_addr", 32'(addr), 32'(e_addr));
        chk(i, "buf_we",   32'(we),   32'(e_we));
        chk(i, "busy",     32'(bsy),  32'(e_busy));
        chk(i, "done",     32'(dn),   32'(e_done));
        if (e_we) begin
            chk(i, "buf_addr", 32'(baddr), 32'(off - 1 - l));
            chk(i, "buf_data", 32'(bdata), 32'(mem[int'(m_first[i]) + off - 1 - l]));
        end
        if (m_just_rst) begin
            chk(i, "rst_buf_addr", 32'(baddr), 32'(0));
            chk(i, "rst_buf_data", 32'(bdata), 32'(0));
        end
        if (in_txn) begin
            if (we) begin
                m_wcount[i]++;
                if (m_first_we[i] < 0) m_first_we[i] = off;
                m_last_we[i] = off;
            end
            if (bsy) m_busy_cnt[i]++;
            if (dn && m_done_off[i] < 0) m_done_off[i] = off;
        end else if (we) begin
            m_we_idle[i]++;
        end
    endtask

    always @(negedge clk) begin
        if (e > 0) begin
            check_dut(0, ram_re_a, ram_addr_a, buf_we_a, buf_addr_a, buf_data_a, busy_a, done_a);
            check_dut(1, ram_re_b, ram_addr_b, buf_we_b, buf_addr_b, buf_data_b, busy_b, done_b);
        end
    end

    // Driver tasks: called just after a negedge; start is sampled at the following posedge.
    task automatic drive_start(input logic re, input logic [AW-1:0] f, input logic [AW-1:0] l);
        re_ram    = re;
        firstaddr = f;
        lastaddr  = l;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        re_ram    = 1'($urandom);
        firstaddr = AW'($urandom);
        lastaddr  = AW'($urandom);
    endtask

    task automatic wait_idle(input int budget);
        int t;
        t = 0;
        while (!(model_idle(0) && model_idle(1)) && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (t >= budget) lit("wait_idle_timeout", t, -1);
        @(negedge clk);
    endtask

    initial begin
        int acc0, t, len, kind, gap;
        logic [AW-1:0] f, l;
        logic re;
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
        rst = 1'b1; start = 1'b0; re_ram = 1'b0; firstaddr = '0; lastaddr = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Full picture load
        drive_start(1'b1, 15'd0, 15'd784);
        wait_idle(2000);
        lit("t1_done_a", m_done_off[0], 786);
        lit("t1_done_b", m_done_off[1], 788);
        lit("t1_wcount_a", m_wcount[0], 784);
        lit("t1_first_we_a", m_first_we[0], 2);

        // conv1 weights
        drive_start(1'b1, 15'd784, 15'd820);
        wait_idle(200);
        lit("t2_done_a", m_done_off[0], 38);
        lit("t2_done_b", m_done_off[1], 40);
        lit("t2_busy_a", m_busy_cnt[0], 37);
        lit("t2_busy_b", m_busy_cnt[1], 39);
        lit("t2_wcount_a", m_wcount[0], 36);
        lit("t2_wcount_b", m_wcount[1], 36);
        lit("t2_first_we_b", m_first_we[1], 4);
        lit("t2_last_we_b", m_last_we[1], 39);

        // Empty ranges
        drive_start(1'b0, 15'd784, 15'd820);
        wait_idle(20);
        lit("t3_done_a", m_done_off[0], 1);
        lit("t3_wcount_b", m_wcount[1], 0);
        lit("t3_busy_b", m_busy_cnt[1], 0);
        drive_start(1'b1, 15'd900, 15'd900);
        wait_idle(20);
        lit("t3_eq_done_b", m_done_off[1], 1);

        // Start during ISSUE is ignored
        acc0 = m_accepts[0];
        drive_start(1'b1, 15'd784, 15'd820);
        repeat (10) @(negedge clk);
        drive_start(1'b1, 15'd100, 15'd200);
        wait_idle(200);
        lit("t4_accepts_a", m_accepts[0] - acc0, 1);
        lit("t4_wcount_a", m_wcount[0], 36);
        lit("t4_done_b", m_done_off[1], 40);

        // Reset in the middle of a long read, then a clean run
        drive_start(1'b1, 15'd0, 15'd784);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        lit("t5_we_after_rst_a", m_we_idle[0], 0);
        lit("t5_we_after_rst_b", m_we_idle[1], 0);
        drive_start(1'b1, 15'd5, 15'd25);
        wait_idle(100);
        lit("t5_wcount_a", m_wcount[0], 20);
        lit("t5_done_b", m_done_off[1], 24);

        // Back-to-back: start in the IDLE cycle right after DONE
        drive_start(1'b1, 15'd10, 15'd14);
        t = 0;
        while (!done_a && t < 50) begin
            @(negedge clk);
            t++;
        end
        lit("t6_done_seen", int'(done_a), 1);
        @(negedge clk);
        acc0 = m_accepts[0];
        drive_start(1'b1, 15'd20, 15'd23);
        lit("t6_accepts_a", m_accepts[0] - acc0, 1);
        wait_idle(100);
        lit("t6_wcount_a", m_wcount[0], 3);
        lit("t6_done_a", m_done_off[0], 5);

        // Random ranges, including empty, reversed, top-of-memory and overlapping starts
        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(0, 9);
            len  = $urandom_range(0, 40);
            f    = AW'($urandom_range(5, 32000));
            l    = AW'(int'(f) + len);
            re   = 1'b1;
            if (kind == 0) re = 1'b0;
            if (kind == 1) l = AW'(int'(f) - $urandom_range(0, 5));
            if (kind == 2) begin
                f = AW'(32767 - len);
                l = 15'd32767;
            end
            drive_start(re, f, l);
            gap = $urandom_range(0, 60);
            repeat (gap) @(negedge clk);
        end
        wait_idle(500);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
